// File: rtl/dpram_pipe_pkg.sv
// Shared constants and helpers for the pipelined dual-port RAM.
// Helpers work on a fixed maximum width; callers extend and truncate.
package dpram_pipe_pkg;

  localparam int unsigned RDW_WRITE_FIRST = 0;
  localparam int unsigned RDW_READ_FIRST  = 1;

  localparam int unsigned MAX_W = 256;
  localparam int unsigned MAX_B = MAX_W / 8;

  // Replace the bytes of old_w selected by be with the bytes of new_w.
  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w,
                                                  input logic [MAX_W-1:0] new_w,
                                                  input logic [MAX_B-1:0] be);
    logic [MAX_W-1:0] merged;
    merged = old_w;
    for (int i = 0; i < int'(MAX_B); i++) begin
      if (be[i]) merged[8*i +: 8] = new_w[8*i +: 8];
    end
    return merged;
  endfunction

  // Even parity: the bit that makes the total number of ones even.
  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// Read output register stage, RD_LAT (1 or 2) deep, carrying data, valid and parity error.
// Data registers load only on valid so the output holds between reads.
module dpram_rd_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_perr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr
);

  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;
  logic              s1_perr_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_perr_q  <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      s1_perr_q  <= in_valid & in_perr;
      if (in_valid) s1_data_q <= in_data;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              s2_valid_q;
    logic [DATA_W-1:0] s2_data_q;
    logic              s2_perr_q;

    always_ff @(posedge clk) begin
      if (!n_rst) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
        s2_perr_q  <= 1'b0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_perr_q  <= s1_perr_q;
        if (s1_valid_q) s2_data_q <= s1_data_q;
      end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_perr  = s2_perr_q;
  end else begin : g_lat1
    assign out_valid = s1_valid_q;
    assign out_data  = s1_data_q;
    assign out_perr  = s1_perr_q;
  end

endmodule

// File: rtl/dpram_pipe.sv
// Flop-based dual-port RAM with byte enables, 1/2-cycle read latency and RDW policy.
// Define DPRAM_PARITY_EN to add per-byte even parity with par_inj / par_err ports.
module dpram_pipe
  import dpram_pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                write_en,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [DATA_W/8-1:0] w_be,
  input  logic [DATA_W-1:0]   datain,
  input  logic                read_en,
  input  logic [ADDR_W-1:0]   r_addr,
`ifdef DPRAM_PARITY_EN
  input  logic                par_inj,
  output logic                par_err,
`endif
  output logic [DATA_W-1:0]   dataout,
  output logic                rd_valid
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [NB-1:0]     be_t;

  if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_bad_width
    $error("dpram_pipe: DATA_W must be a non-zero multiple of 8");
  end
  if (DATA_W > MAX_W) begin : g_too_wide
    $error("dpram_pipe: DATA_W exceeds helper width");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("dpram_pipe: RD_LAT must be 1 or 2");
  end
  if (RDW_MODE != RDW_WRITE_FIRST && RDW_MODE != RDW_READ_FIRST) begin : g_bad_rdw
    $error("dpram_pipe: RDW_MODE must be 0 or 1");
  end

  word_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (write_en) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (w_be[b]) mem_q[w_addr][8*b +: 8] <= datain[8*b +: 8];
      end
    end
  end

  word_t rd_stored;
  word_t rd_word;
  be_t   rd_bypass_be;
  logic  rd_hit;
  logic  rd_perr;

  // Write-first bypass is a byte merge of the stored word with this cycle's write data.
  always_comb begin
    rd_stored    = mem_q[r_addr];
    rd_hit       = write_en && (w_addr == r_addr);
    rd_bypass_be = (RDW_MODE == RDW_WRITE_FIRST && rd_hit) ? w_be : '0;
    rd_word      = word_t'(byte_merge(MAX_W'(rd_stored), MAX_W'(datain), MAX_B'(rd_bypass_be)));
  end

`ifdef DPRAM_PARITY_EN
  be_t par_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) par_q[i] <= '0;
    end else if (write_en) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (w_be[b]) par_q[w_addr][b] <= byte_par(datain[8*b +: 8]) ^ par_inj;
      end
    end
  end

  // Bypassed bytes carry fresh data, so only stored bytes are checked.
  always_comb begin
    rd_perr = 1'b0;
    for (int b = 0; b < int'(NB); b++) begin
      if (!rd_bypass_be[b] && (par_q[r_addr][b] != byte_par(rd_stored[8*b +: 8]))) begin
        rd_perr = 1'b1;
      end
    end
  end
`else
  assign rd_perr = 1'b0;
  logic unused_par_err;
`endif

  dpram_rd_pipe #(
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .n_rst    (n_rst),
    .in_valid (read_en),
    .in_data  (rd_word),
    .in_perr  (rd_perr),
    .out_valid(rd_valid),
    .out_data (dataout),
`ifdef DPRAM_PARITY_EN
    .out_perr (par_err)
`else
    .out_perr (unused_par_err)
`endif
  );

endmodule

// File: tb/tb_dpram_pipe.sv
// Bench for dpram_pipe: two instances (RD_LAT=1/write-first, RD_LAT=2/read-first) share stimulus
// and are compared each cycle against a cycle-scheduled reference model.
module tb_dpram_pipe;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        write_en;
  logic [3:0]  w_addr;
  logic [3:0]  w_be;
  logic [31:0] datain;
  logic        read_en;
  logic [3:0]  r_addr;
  logic        par_inj;

  logic [31:0] dout0, dout1;
  logic        v0, v1;
`ifdef DPRAM_PARITY_EN
  logic        pe0, pe1;
`endif

  always #5 clk = ~clk;

  dpram_pipe #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(0)) u_dut0 (
    .clk(clk), .n_rst(n_rst), .write_en(write_en), .w_addr(w_addr), .w_be(w_be),
    .datain(datain), .read_en(read_en), .r_addr(r_addr),
`ifdef DPRAM_PARITY_EN
    .par_inj(par_inj), .par_err(pe0),
`endif
    .dataout(dout0), .rd_valid(v0)
  );

  dpram_pipe #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .RDW_MODE(1)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .write_en(write_en), .w_addr(w_addr), .w_be(w_be),
    .datain(datain), .read_en(read_en), .r_addr(r_addr),
`ifdef DPRAM_PARITY_EN
    .par_inj(par_inj), .par_err(pe1),
`endif
    .dataout(dout1), .rd_valid(v1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: array memory plus results scheduled by the cycle they appear.
  int          lat  [2] = '{1, 2};
  int          mode [2] = '{0, 1};
  logic [31:0] m_mem [16];
  logic [3:0]  m_par [16];
  logic        sv [2][4];
  logic [31:0] sd [2][4];
  logic        se [2][4];
  logic        exp_v [2];
  logic [31:0] exp_d [2];
  logic        exp_e [2];
  int          k = 0;

  task automatic model_step();
    k++;
    if (!n_rst) begin
      for (int a = 0; a < 16; a++) begin
        m_mem[a] = '0;
        m_par[a] = '0;
      end
      for (int i = 0; i < 2; i++) begin
        for (int s = 0; s < 4; s++) sv[i][s] = 1'b0;
        exp_v[i] = 1'b0;
        exp_d[i] = '0;
        exp_e[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (read_en) begin
          logic [31:0] res;
          logic        err;
          logic [7:0]  sb;
          int          slot;
          err = 1'b0;
          for (int b = 0; b < 4; b++) begin
            sb = m_mem[r_addr][8*b +: 8];
            if (mode[i] == 0 && write_en && w_addr == r_addr && w_be[b]) begin
              res[8*b +: 8] = datain[8*b +: 8];
            end else begin
              res[8*b +: 8] = sb;
              if (m_par[r_addr][b] != ^sb) err = 1'b1;
            end
          end
          slot = (k + lat[i] - 1) % 4;
          sv[i][slot] = 1'b1;
          sd[i][slot] = res;
          se[i][slot] = err;
        end
        exp_v[i] = sv[i][k % 4];
        exp_e[i] = sv[i][k % 4] & se[i][k % 4];
        if (sv[i][k % 4]) exp_d[i] = sd[i][k % 4];
        sv[i][k % 4] = 1'b0;
      end
      if (write_en) begin
        for (int b = 0; b < 4; b++) begin
          if (w_be[b]) begin
            m_mem[w_addr][8*b +: 8] = datain[8*b +: 8];
            m_par[w_addr][b] = (^datain[8*b +: 8]) ^ par_inj;
          end
        end
      end
    end
  endtask

  task automatic compare();
    check("valid0", {31'b0, v0}, {31'b0, exp_v[0]});
    check("data0", dout0, exp_d[0]);
    check("valid1", {31'b0, v1}, {31'b0, exp_v[1]});
    check("data1", dout1, exp_d[1]);
`ifdef DPRAM_PARITY_EN
    check("perr0", {31'b0, pe0}, {31'b0, exp_e[0]});
    check("perr1", {31'b0, pe1}, {31'b0, exp_e[1]});
`endif
  endtask

  task automatic cycle(input logic rst, input logic we, input logic [3:0] wa,
                       input logic [3:0] be, input logic [31:0] din, input logic re,
                       input logic [3:0] ra, input logic inj);
    n_rst    = rst;
    write_en = we;
    w_addr   = wa;
    w_be     = be;
    datain   = din;
    read_en  = re;
    r_addr   = ra;
`ifdef DPRAM_PARITY_EN
    par_inj  = inj;
`else
    par_inj  = 1'b0;
    if (inj) par_inj = 1'b0;
`endif
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    cycle(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    cycle(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
    check("rst_dout0", dout0, 32'h0);
    check("rst_dout1", dout1, 32'h0);

    // Read of a reset location
    cycle(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd3, 1'b0);
    check("rd3_lat1_valid", {31'b0, v0}, 32'd1);
    idle(1);
    check("rd3_lat2_valid", {31'b0, v1}, 32'd1);
    check("rd3_data1", dout1, 32'h0);

    // Full write then read
    cycle(1'b1, 1'b1, 4'd5, 4'hF, 32'hDEADBEEF, 1'b0, 4'h0, 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd5, 1'b0);
    idle(2);
    check("wr5_data0", dout0, 32'hDEADBEEF);
    check("wr5_data1", dout1, 32'hDEADBEEF);

    // Same-address read during byte-masked write
    cycle(1'b1, 1'b1, 4'd5, 4'b0101, 32'h11223344, 1'b1, 4'd5, 1'b0);
    idle(2);
    check("rdw_wfirst", dout0, 32'hDE22BE44);
    check("rdw_rfirst", dout1, 32'hDEADBEEF);
    cycle(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd5, 1'b0);
    idle(2);
    check("rdw_after0", dout0, 32'hDE22BE44);
    check("rdw_after1", dout1, 32'hDE22BE44);

    // Back-to-back reads
    cycle(1'b1, 1'b1, 4'd0, 4'hF, 32'hA, 1'b0, 4'h0, 1'b0);
    cycle(1'b1, 1'b1, 4'd1, 4'hF, 32'hB, 1'b0, 4'h0, 1'b0);
    cycle(1'b1, 1'b1, 4'd2, 4'hF, 32'hC, 1'b0, 4'h0, 1'b0);
    for (int a = 0; a < 3; a++) cycle(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a), 1'b0);
    idle(3);
    check("b2b_hold0", dout0, 32'hC);
    check("b2b_hold1", dout1, 32'hC);

    // Reset right after a read, with a write in the reset cycle
    cycle(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd5, 1'b0);
    cycle(1'b0, 1'b1, 4'd6, 4'hF, 32'h12345678, 1'b0, 4'h0, 1'b0);
    check("rst_drop_v1", {31'b0, v1}, 32'd0);
    check("rst_drop_d1", dout1, 32'h0);
    idle(2);
    check("rst_drop_v1b", {31'b0, v1}, 32'd0);
    for (int a = 0; a < 16; a++) cycle(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a), 1'b0);
    idle(2);
    check("rst_clear0", dout0, 32'h0);
    check("rst_clear1", dout1, 32'h0);

    // Parity injection and repair
    cycle(1'b1, 1'b1, 4'd7, 4'hF, 32'h0F0F0001, 1'b0, 4'h0, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd7, 1'b0);
`ifdef DPRAM_PARITY_EN
    check("par_inj0", {31'b0, pe0}, 32'd1);
`endif
    idle(2);
    cycle(1'b1, 1'b1, 4'd7, 4'hF, 32'h0F0F0001, 1'b0, 4'h0, 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd7, 1'b0);
`ifdef DPRAM_PARITY_EN
    check("par_ok0", {31'b0, pe0}, 32'd0);
`endif
    idle(2);

    // Random traffic, biased toward same-address collisions
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] wa;
      logic [3:0] ra;
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      cycle(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)), wa, 4'($urandom),
            $urandom, 1'($urandom_range(0, 1)), ra, ($urandom_range(0, 7) == 0));
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dpram_pipe.md
Name: dpram_pipe

Overview:
Parametrised successor to the single-width dual-port RAM: one write port and one read port, flop-based storage, configurable width and depth. Adds per-byte write enables, a selectable read latency of 1 or 2 cycles with a read-valid strobe, and a selectable read-during-write policy. Sits in the same verification environment as a drop-in storage block for UVM benches.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2 only.
- RDW_MODE, 0, same-address read-during-write policy: 0 = write-first (new data bypassed), 1 = read-first (old data).

Ports:
- clk  in  1  single clock; one clock; reset is synchronous and active-low.
- n_rst  in  1  synchronous active-low reset, sampled on posedge clk.
- write_en  in  1  write request this cycle.
- w_addr  in  ADDR_W  write address.
- w_be  in  DATA_W/8  byte enables; bit i covers datain[8i+7:8i].
- datain  in  DATA_W  write data.
- read_en  in  1  read request this cycle.
- r_addr  in  ADDR_W  read address.
- dataout  out  DATA_W  read data; holds its value between reads.
- rd_valid  out  1  one-cycle pulse marking new dataout.

Behaviour:
- Reset: on a posedge clk with n_rst=0, all RAM words, dataout, rd_valid and the internal pipeline registers clear to 0. A read in flight is dropped (no rd_valid). A write in the reset cycle is discarded.
- Write: at posedge with write_en=1, RAM[w_addr] byte i is updated iff w_be[i]=1. write_en=1 with w_be=0 is a no-op.
- Read request at cycle t (read_en=1) samples the RAM contents as they stand after all writes up to cycle t-1:
  - RDW_MODE=0 and write_en=1 and w_addr==r_addr at cycle t: result = stored word with the enabled bytes replaced by datain (byte-merged bypass).
  - RDW_MODE=1: result = stored word before the cycle-t write.
  - Writes at t+1 and later never affect a read issued at t.
- Latency:
  - RD_LAT=1: dataout and rd_valid=1 are updated at the posedge ending cycle t.
  - RD_LAT=2: the result passes through one extra register stage; dataout and rd_valid update one cycle later.
- Back-to-back reads every cycle are fully pipelined: one result per cycle, in order.
- dataout changes only when rd_valid is asserted.
- read_en=0 produces no update and rd_valid=0.
- Address compare is exact over ADDR_W bits; no out-of-range addresses exist.
- Illegal RD_LAT or a DATA_W not divisible by 8 triggers an elaboration-time $error.

Optional Feature:
DPRAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte (written with the byte; cleared to 0 on reset).
  - New output par_err (1 bit, reset 0) is aligned with rd_valid. It is 1 when any returned byte's recomputed parity mismatches its stored bit.
  - Bypassed bytes in RDW_MODE=0 use freshly computed parity and never flag.
  - New input par_inj (1 bit) inverts the stored parity bits of the bytes being written, for test.
- Undefined: neither port exists and no parity storage is built.

Decomposition:
- Package dpram_pipe_pkg holds:
  - RDW_WRITE_FIRST / RDW_READ_FIRST constants;
  - a byte-merge function (old word, new word, be -> merged);
  - a parity function.
- Parametrised typedefs stay local to the module because they are width-dependent.
- One natural sub-module: dpram_rd_pipe, the RD_LAT-deep output register stage carrying data, valid and parity error, with synchronous reset.

Test Plan:
- Reset, then read addr 3 -> rd_valid=1 after RD_LAT cycles, dataout=0x00000000.
- Write 0xDEADBEEF to addr 5 with be=4'hF; next cycle read addr 5 -> dataout=0xDEADBEEF.
- Addr 5 holds 0xDEADBEEF. Same cycle: write 0x11223344 with be=4'b0101 to addr 5 and read addr 5.
  - RDW_MODE=0 -> dataout=0xDE22BE44.
  - RDW_MODE=1 -> dataout=0xDEADBEEF.
  - Next read -> 0xDE22BE44 in both modes.
- RD_LAT=2: reads of addr 0,1,2 on consecutive cycles (preloaded with 0xA,0xB,0xC) -> rd_valid high for 3 consecutive cycles starting 2 cycles later, data 0xA,0xB,0xC in order; dataout holds 0xC afterwards.
- Read issued, n_rst=0 asserted the following cycle -> no rd_valid pulse, dataout=0, all addresses read back 0 after reset.
- With DPRAM_PARITY_EN: write addr 7 with par_inj=1, read addr 7 -> par_err=1 with rd_valid. Rewrite with par_inj=0, read again -> par_err=0.
